// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared types, ternary weight encoding and width helpers for the ternary classifier
package tnn_pkg;

   localparam logic [1:0] TW_ZERO = 2'b00;
   localparam logic [1:0] TW_POS  = 2'b01;
   localparam logic [1:0] TW_NEG  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      L1,
      L2,
      ARG,
      DONE
   } tnn_state_t;

   // Worst case |acc1| is F * (2^FEAT_BITS - 1), plus one sign bit.
   function automatic int acc1_width(input int feat_bits, input int feat_cnt);
      return feat_bits + $clog2(feat_cnt + 1) + 1;
   endfunction

   function automatic int score_width(input int hidden_cnt);
      return $clog2(hidden_cnt + 1) + 1;
   endfunction

   function automatic int idx_width(input int class_cnt);
      return (class_cnt > 1) ? $clog2(class_cnt) : 1;
   endfunction

   // 2'b10 is an unused code and behaves as zero.
   function automatic logic signed [1:0] tw_decode(input logic [1:0] w);
      case (w)
         TW_POS:  return 2'sd1;
         TW_NEG:  return -2'sd1;
         TW_ZERO: return 2'sd0;
         default: return 2'sd0;
      endcase
   endfunction

endpackage

// File: rtl/tnn_seq_argmax.sv
// rtl/tnn_seq_argmax.sv - sequential argmax over class scores, one class per cycle, ties to lowest index
module tnn_seq_argmax
   import tnn_pkg::*;
#(
   parameter int CLASS_CNT = 10,
   parameter int SCORE_W   = 7,
   localparam int IDX_W    = idx_width(CLASS_CNT)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [CLASS_CNT*SCORE_W-1:0] scores,
   output logic                         done,
   output logic [IDX_W-1:0]             best_idx,
   output logic signed [SCORE_W-1:0]    best_score
);

   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(CLASS_CNT - 1);

   logic                      busy;
   logic [IDX_W-1:0]          k;
   logic [IDX_W-1:0]          run_idx;
   logic signed [SCORE_W-1:0] run_best;
   logic signed [SCORE_W-1:0] cur;
   logic                      take;

   // best_idx/best_score already include the class under scan, so the
   // done cycle hands out the final winner without an extra register stage.
   always_comb begin
      cur = '0;
      for (int c = 0; c < CLASS_CNT; c++) begin
         if (k == IDX_W'(c)) cur = scores[c*SCORE_W +: SCORE_W];
      end
      take       = (k == '0) || (cur > run_best);
      best_idx   = take ? k : run_idx;
      best_score = take ? cur : run_best;
      done       = busy && (k == K_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         k        <= '0;
         run_idx  <= '0;
         run_best <= '0;
      end else if (start) begin
         busy <= 1'b1;
         k    <= '0;
      end else if (busy) begin
         run_idx  <= best_idx;
         run_best <= best_score;
         if (k == K_LAST) begin
            busy <= 1'b0;
            k    <= '0;
         end else begin
            k <= k + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/tnn_seq_classifier.sv
// rtl/tnn_seq_classifier.sv - streaming ternary NN classifier: hidden layer, output layer, argmax
module tnn_seq_classifier
   import tnn_pkg::*;
#(
   parameter int FEAT_CNT   = 16,
   parameter int FEAT_BITS  = 4,
   parameter int HIDDEN_CNT = 40,
   parameter int CLASS_CNT  = 10,
   parameter logic [2*HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '0,
   parameter logic [2*CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0,
   localparam int SCORE_W = score_width(HIDDEN_CNT),
   localparam int IDX_W   = idx_width(CLASS_CNT)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [FEAT_BITS*FEAT_CNT-1:0] data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [IDX_W-1:0]              prediction,
   output logic [SCORE_W-1:0]            score,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int ACC1_W  = acc1_width(FEAT_BITS, FEAT_CNT);
   localparam int CNT_MAX = (FEAT_CNT > HIDDEN_CNT) ? FEAT_CNT : HIDDEN_CNT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] L1_LAST = CNT_W'(FEAT_CNT - 1);
   localparam logic [CNT_W-1:0] L2_LAST = CNT_W'(HIDDEN_CNT - 1);
   localparam logic signed [SCORE_W-1:0] ONE = SCORE_W'(1);

   tnn_state_t state, next_state;

   logic [CNT_W-1:0]              step;
   logic [FEAT_BITS*FEAT_CNT-1:0] data_q;
   logic signed [ACC1_W-1:0]      acc1     [HIDDEN_CNT];
   logic signed [ACC1_W-1:0]      acc1_nxt [HIDDEN_CNT];
   logic signed [SCORE_W-1:0]     acc2     [CLASS_CNT];
   logic signed [SCORE_W-1:0]     acc2_nxt [CLASS_CNT];
   logic [1:0]                    w1_col   [HIDDEN_CNT];
   logic [1:0]                    w2_col   [CLASS_CNT];
   logic [FEAT_BITS-1:0]          feat_cur;
   logic signed [ACC1_W-1:0]      feat_ext;
   logic                          h_cur;
   logic [CLASS_CNT*SCORE_W-1:0]  scores_flat;

   logic                          accept;
   logic                          l1_last;
   logic                          l2_last;
   logic                          arg_done;
   logic [IDX_W-1:0]              arg_idx;
   logic signed [SCORE_W-1:0]     arg_best;

   assign accept  = in_valid && in_ready;
   assign l1_last = (state == L1) && (step == L1_LAST);
   assign l2_last = (state == L2) && (step == L2_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept)    next_state = L1;
         L1:      if (l1_last)   next_state = L2;
         L2:      if (l2_last)   next_state = ARG;
         ARG:     if (arg_done)  next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Select the current column: feature i for L1, hidden bit h[j] for L2.
   always_comb begin
      feat_cur = '0;
      h_cur    = 1'b0;
      for (int j = 0; j < HIDDEN_CNT; j++) w1_col[j] = TW_ZERO;
      for (int k = 0; k < CLASS_CNT; k++)  w2_col[k] = TW_ZERO;
      for (int i = 0; i < FEAT_CNT; i++) begin
         if (step == CNT_W'(i)) begin
            feat_cur = data_q[i*FEAT_BITS +: FEAT_BITS];
            for (int j = 0; j < HIDDEN_CNT; j++) w1_col[j] = W1[2*(j*FEAT_CNT+i) +: 2];
         end
      end
      for (int j = 0; j < HIDDEN_CNT; j++) begin
         if (step == CNT_W'(j)) begin
            h_cur = ~acc1[j][ACC1_W-1];
            for (int k = 0; k < CLASS_CNT; k++) w2_col[k] = W2[2*(k*HIDDEN_CNT+j) +: 2];
         end
      end
   end

   always_comb begin
      feat_ext = {{(ACC1_W-FEAT_BITS){1'b0}}, feat_cur};
      for (int j = 0; j < HIDDEN_CNT; j++) begin
         acc1_nxt[j] = acc1[j];
         if (tw_decode(w1_col[j]) == 2'sd1)       acc1_nxt[j] = acc1[j] + feat_ext;
         else if (tw_decode(w1_col[j]) == -2'sd1) acc1_nxt[j] = acc1[j] - feat_ext;
      end
      for (int k = 0; k < CLASS_CNT; k++) begin
         acc2_nxt[k] = acc2[k];
         if (tw_decode(w2_col[k]) == 2'sd1)       acc2_nxt[k] = h_cur ? acc2[k] + ONE : acc2[k] - ONE;
         else if (tw_decode(w2_col[k]) == -2'sd1) acc2_nxt[k] = h_cur ? acc2[k] - ONE : acc2[k] + ONE;
      end
      for (int k = 0; k < CLASS_CNT; k++) scores_flat[k*SCORE_W +: SCORE_W] = acc2[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step       <= '0;
         data_q     <= '0;
         prediction <= '0;
         score      <= '0;
         for (int j = 0; j < HIDDEN_CNT; j++) acc1[j] <= '0;
         for (int k = 0; k < CLASS_CNT; k++)  acc2[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q <= data;
                  step   <= '0;
                  for (int j = 0; j < HIDDEN_CNT; j++) acc1[j] <= '0;
                  for (int k = 0; k < CLASS_CNT; k++)  acc2[k] <= '0;
               end
            end
            L1: begin
               for (int j = 0; j < HIDDEN_CNT; j++) acc1[j] <= acc1_nxt[j];
               step <= l1_last ? '0 : step + CNT_W'(1);
            end
            L2: begin
               for (int k = 0; k < CLASS_CNT; k++) acc2[k] <= acc2_nxt[k];
               step <= l2_last ? '0 : step + CNT_W'(1);
            end
            ARG: begin
               if (arg_done) begin
                  prediction <= arg_idx;
                  score      <= arg_best;
               end
            end
            default: ;
         endcase
      end
   end

   tnn_seq_argmax #(
      .CLASS_CNT (CLASS_CNT),
      .SCORE_W   (SCORE_W)
   ) u_argmax (
      .clk        (clk),
      .rst        (rst),
      .start      (l2_last),
      .scores     (scores_flat),
      .done       (arg_done),
      .best_idx   (arg_idx),
      .best_score (arg_best)
   );

endmodule

// File: tb/tb_tnn_seq_classifier.sv
// tb/tb_tnn_seq_classifier.sv - directed self-checking bench for tnn_seq_classifier
module tb_tnn_seq_classifier;

   // F=2, H=2, C=2: h0=+f0, h1=-f0; class0={+h0}, class1={+h0,-h1}
   localparam logic [7:0] SW1     = 8'h31;
   localparam logic [7:0] SW2     = 8'hD1;
   localparam logic [7:0] SW2_TIE = 8'h11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [63:0] d_data;
   logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [3:0]  d_pred;
   logic [6:0]  d_score;

   logic [7:0]  a_data;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [0:0]  a_pred;
   logic [2:0]  a_score;

   logic [7:0]  b_data;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [0:0]  b_pred;
   logic [2:0]  b_score;

   int total;
   int bad;

   tnn_seq_classifier u_dflt (
      .clk(clk), .rst(rst), .data(d_data), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .prediction(d_pred), .score(d_score), .out_valid(d_out_valid), .out_ready(d_out_ready)
   );

   tnn_seq_classifier #(
      .FEAT_CNT(2), .FEAT_BITS(4), .HIDDEN_CNT(2), .CLASS_CNT(2), .W1(SW1), .W2(SW2)
   ) u_small (
      .clk(clk), .rst(rst), .data(a_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .prediction(a_pred), .score(a_score), .out_valid(a_out_valid), .out_ready(a_out_ready)
   );

   tnn_seq_classifier #(
      .FEAT_CNT(2), .FEAT_BITS(4), .HIDDEN_CNT(2), .CLASS_CNT(2), .W1(SW1), .W2(SW2_TIE)
   ) u_tie (
      .clk(clk), .rst(rst), .data(b_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .prediction(b_pred), .score(b_score), .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Called just after an edge; returns the edge count from accept to out_valid.
   task automatic run_a(input logic [7:0] din, input logic [7:0] junk, output int lat);
      a_data     = din;
      a_in_valid = 1'b1;
      check_val("a_accept_ready", a_in_ready, 1);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      a_data     = junk;
      lat = 0;
      while (lat < 200 && !a_out_valid) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic hs_a();
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      check_val("a_hs_in_ready", a_in_ready, 1);
      check_val("a_hs_out_valid", a_out_valid, 0);
   endtask

   logic [7:0] smp   [3];
   int         exp_p [3];
   int         exp_s [3];
   int         acc_edge [3];

   initial begin
      int lat;
      int seen;
      int n_acc;
      int n_res;
      int cyc;
      logic rdy_prev;

      total = 0;
      bad   = 0;
      rst = 1'b1;
      d_data = '0; d_in_valid = 1'b0; d_out_ready = 1'b0;
      a_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      b_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
      smp[0] = 8'h05; exp_p[0] = 1; exp_s[0] = 2;
      smp[1] = 8'h00; exp_p[1] = 0; exp_s[1] = 1;
      smp[2] = 8'hF3; exp_p[2] = 1; exp_s[2] = 2;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check_val("rst_d_in_ready", d_in_ready, 1);
      check_val("rst_d_out_valid", d_out_valid, 0);
      check_val("rst_d_pred", d_pred, 0);
      check_val("rst_d_score", d_score, 0);
      check_val("rst_a_in_ready", a_in_ready, 1);
      check_val("rst_a_out_valid", a_out_valid, 0);
      check_val("rst_a_pred", a_pred, 0);
      check_val("rst_a_score", a_score, 0);

      // default configuration, zero weights
      d_data     = 64'h0123456789ABCDEF;
      d_in_valid = 1'b1;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      d_data     = '1;
      lat = 0;
      while (lat < 200 && !d_out_valid) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("dflt_latency", lat, 66);
      check_val("dflt_pred", d_pred, 0);
      check_val("dflt_score", d_score, 0);
      d_out_ready = 1'b1;
      @(posedge clk); #1;
      d_out_ready = 1'b0;
      check_val("dflt_hs_in_ready", d_in_ready, 1);
      check_val("dflt_hs_out_valid", d_out_valid, 0);

      // class 1 wins, then held under backpressure
      run_a(8'h05, 8'h00, lat);
      check_val("c1_latency", lat, 6);
      check_val("c1_pred", a_pred, 1);
      check_val("c1_score", a_score, 2);
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         check_val("bp_pred", a_pred, 1);
         check_val("bp_score", a_score, 2);
         check_val("bp_out_valid", a_out_valid, 1);
         check_val("bp_in_ready", a_in_ready, 0);
      end
      hs_a();

      // tie-break: class0 scores 1, class1 scores 0
      run_a(8'h00, 8'hF7, lat);
      check_val("tie0_latency", lat, 6);
      check_val("tie0_pred", a_pred, 0);
      check_val("tie0_score", a_score, 1);
      hs_a();

      // exact tie at 1 on the second weight set
      b_data     = 8'h00;
      b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      b_data     = 8'h09;
      lat = 0;
      while (lat < 200 && !b_out_valid) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("tie1_latency", lat, 6);
      check_val("tie1_pred", b_pred, 0);
      check_val("tie1_score", b_score, 1);
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      check_val("tie1_hs_in_ready", b_in_ready, 1);

      // reset while in L2
      a_data     = 8'h05;
      a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("rstl2_in_ready", a_in_ready, 1);
      check_val("rstl2_out_valid", a_out_valid, 0);
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (a_out_valid) seen = 1;
      end
      check_val("rstl2_no_result", seen, 0);
      run_a(8'hF3, 8'h00, lat);
      check_val("post_rst_latency", lat, 6);
      check_val("post_rst_pred", a_pred, 1);
      check_val("post_rst_score", a_score, 2);
      hs_a();

      // back-to-back with out_ready held high
      n_acc = 0;
      n_res = 0;
      cyc   = 0;
      a_out_ready = 1'b1;
      a_data      = smp[0];
      a_in_valid  = 1'b1;
      rdy_prev    = a_in_ready;
      while (n_res < 3 && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         if (rdy_prev && a_in_valid && n_acc < 3) begin
            acc_edge[n_acc] = cyc;
            n_acc++;
            if (n_acc < 3) begin
               a_data = smp[n_acc];
            end else begin
               a_in_valid = 1'b0;
               a_data     = 8'h00;
            end
         end
         if (a_out_valid && n_res < 3) begin
            check_val("b2b_pred", a_pred, exp_p[n_res]);
            check_val("b2b_score", a_score, exp_s[n_res]);
            n_res++;
         end
         rdy_prev = a_in_ready;
      end
      a_out_ready = 1'b0;
      a_in_valid  = 1'b0;
      check_val("b2b_results", n_res, 3);
      check_val("b2b_accepts", n_acc, 3);
      if (n_acc == 3) begin
         check_val("b2b_gap1", acc_edge[1] - acc_edge[0], 8);
         check_val("b2b_gap2", acc_edge[2] - acc_edge[1], 8);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
